// File: rtl/btn_pkg.sv
// Shared constants for the button front end: bit positions of each button in
// the pressed vector and the encoding of the up/down auto-repeat state.
package btn_pkg;

  localparam int NUM_BTN = 5;
  localparam int BTN_U   = 4;
  localparam int BTN_D   = 3;
  localparam int BTN_R   = 2;
  localparam int BTN_L   = 1;
  localparam int BTN_C   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle between the raw buttons and the alarm-clock logic. The slave side is
// the conditioner; the master side drives the buttons and consumes the pulses.
interface button_conditioner_if;
  import btn_pkg::*;

  // No valid/ready here: every output is a strobe or a level with no
  // backpressure, so a pulse is consumed in the single cycle it is high.
  logic       U, D, R, L, C;
  logic       up, down, right, left, center;
  logic [4:0] pressed;
  logic       tick;
  rpt_state_t up_state, down_state;

  modport master (
    output U, D, R, L, C,
    input  up, down, right, left, center, pressed, tick, up_state, down_state
  );

  modport slave (
    input  U, D, R, L, C,
    output up, down, right, left, center, pressed, tick, up_state, down_state
  );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, tick-sampled debounce and a
// registered one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (tick) begin
        if (sync2 == level) begin
          cnt <= '0;
        // The increment that would reach DEB_TICKS is the one that flips the level.
        end else if (cnt == CW'(DEB_TICKS - 1)) begin
          level <= ~level;
          rise  <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five-button front end: sample-tick prescaler, per-button debounce, and
// auto-repeat for up/down with mutual suppression while both are held.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int DEB_TICKS    = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;

  assign raw_vec = {bus.U, bus.D, bus.R, bus.L, bus.C};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (raw_vec[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Both up and down held is treated as a mistake: neither may scroll.
  logic conflict;
  assign conflict = level[BTN_U] & level[BTN_D];

  logic [1:0] rpt_pulse;
  rpt_state_t rpt_state [2];

  for (genvar c = 0; c < 2; c++) begin : g_rpt
    localparam int B = (c == 0) ? BTN_U : BTN_D;

    rpt_state_t    state;
    logic [RW-1:0] cnt;
    logic          pulse;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (conflict) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise[B]) begin
                state <= HOLD;
                cnt   <= '0;
              end
            end
            HOLD: begin
              if (!level[B]) begin
                state <= IDLE;
              end else if (tick) begin
                if (cnt == RW'(REPEAT_DELAY - 1)) begin
                  pulse <= 1'b1;
                  cnt   <= '0;
                  state <= REPEAT;
                end else begin
                  cnt <= cnt + RW'(1);
                end
              end
            end
            REPEAT: begin
              if (!level[B]) begin
                state <= IDLE;
              end else if (tick) begin
                if (cnt == RW'(REPEAT_RATE - 1)) begin
                  pulse <= 1'b1;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + RW'(1);
                end
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign rpt_pulse[c] = pulse;
    assign rpt_state[c] = state;
  end

  assign bus.up         = rise[BTN_U] | rpt_pulse[0];
  assign bus.down       = rise[BTN_D] | rpt_pulse[1];
  assign bus.right      = rise[BTN_R];
  assign bus.left       = rise[BTN_L];
  assign bus.center     = rise[BTN_C];
  assign bus.pressed    = level;
  assign bus.tick       = tick;
  assign bus.up_state   = rpt_state[0];
  assign bus.down_state = rpt_state[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with small timing parameters: a tick-indexed
// behavioural model predicts every output each cycle, plus directed checks.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 8;
  localparam int RR = 4;
  localparam int W  = 11;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] raw;
  button_conditioner_if bus ();

  assign bus.U = raw[BTN_U];
  assign bus.D = raw[BTN_D];
  assign bus.R = raw[BTN_R];
  assign bus.L = raw[BTN_L];
  assign bus.C = raw[BTN_C];

  button_conditioner #(
    .TICK_DIV     (TD),
    .DEB_TICKS    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: everything is expressed in tick indices since reset.
  logic [4:0] hist_q[$];
  logic [4:0] m_level, m_rise;
  logic [1:0] m_pulse, m_active;
  logic       m_tick;
  int         m_start[2];
  int         anchor[5];
  int         m_tk;
  int         n;

  // Per-run observations.
  int pcnt[5];
  int first_up, first_tick;
  int dq[$];
  logic [4:0] seen_level;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist_q.delete();
    hist_q.push_back(5'd0);
    hist_q.push_back(5'd0);
    m_level  = '0;
    m_rise   = '0;
    m_pulse  = '0;
    m_active = '0;
    m_tick   = 1'b0;
    m_tk     = 0;
    n        = 0;
    for (int b = 0; b < 5; b++) anchor[b] = 0;
    for (int c = 0; c < 2; c++) m_start[c] = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge, using values visible before it.
  task automatic model_edge();
    logic [4:0] s, nl, nr;
    logic [1:0] np;
    int t;
    s = hist_q[hist_q.size() - 2];
    hist_q.push_back(raw);
    if (hist_q.size() > 2) void'(hist_q.pop_front());
    t  = m_tk + (m_tick ? 1 : 0);
    np = '0;
    for (int c = 0; c < 2; c++) begin
      int b;
      int h;
      b = (c == 0) ? BTN_U : BTN_D;
      if (m_level[BTN_U] && m_level[BTN_D]) begin
        m_active[c] = 1'b0;
      end else if (!m_active[c]) begin
        if (m_rise[b]) begin
          m_active[c] = 1'b1;
          m_start[c]  = t;
        end
      end else if (!m_level[b]) begin
        m_active[c] = 1'b0;
      end else if (m_tick) begin
        h     = t - m_start[c];
        np[c] = (h == RD) || (h > RD && ((h - RD) % RR) == 0);
      end
    end
    nl = m_level;
    nr = '0;
    if (m_tick) begin
      for (int b = 0; b < 5; b++) begin
        if (s[b] == m_level[b]) begin
          anchor[b] = t;
        end else if (t - anchor[b] == DB) begin
          nl[b]     = ~m_level[b];
          nr[b]     = nl[b];
          anchor[b] = t;
        end
      end
    end
    m_level = nl;
    m_rise  = nr;
    m_pulse = np;
    m_tk    = t;
    n++;
    m_tick  = (n % TD) == 0;
    exp_q.push_back({m_rise[BTN_U] | m_pulse[0], m_rise[BTN_D] | m_pulse[1],
                     m_rise[BTN_R], m_rise[BTN_L], m_rise[BTN_C], m_level, m_tick});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [W-1:0] obs, exp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    obs = {bus.up, bus.down, bus.right, bus.left, bus.center, bus.pressed, bus.tick};
    exp = exp_q.pop_front();
    check("cycle_outputs", 32'(obs), 32'(exp));
    for (int b = 0; b < 5; b++) if (obs[6+b]) pcnt[b]++;
    if (obs[6+BTN_U] && first_up < 0) first_up = n;
    if (obs[6+BTN_D]) dq.push_back(n);
    if (obs[0] && first_tick < 0) first_tick = n;
    seen_level |= obs[5:1];
  endtask

  // Called at time 0 or right after a step (at a falling edge).
  task automatic apply_reset(input logic [4:0] hold);
    raw = hold;
    #1 rst = 1'b0;
    #1;
    check("reset_outputs", 32'({bus.up, bus.down, bus.right, bus.left, bus.center,
                                bus.pressed, bus.tick}), 32'd0);
    check("reset_up_state", 32'(bus.up_state), 32'(IDLE));
    check("reset_down_state", 32'(bus.down_state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int b = 0; b < 5; b++) pcnt[b] = 0;
    first_up   = -1;
    first_tick = -1;
    dq.delete();
    seen_level = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  int jl[7] = '{0, 8, 12, 16, 20, 24, 28};
  int rem[5];

  initial begin
    raw = '0;
    rst = 1'b0;

    // Clean press of U from the first cycle after reset.
    apply_reset(5'b10000);
    for (int i = 0; i < 40; i++) step();
    check("first_tick_after_reset", 32'(first_tick), 32'd4);
    check("up_pulse_count", 32'(pcnt[BTN_U]), 32'd1);
    check("up_latency_window", 32'(first_up >= 11 && first_up <= 15), 32'd1);
    check("up_level_held", 32'(bus.pressed[BTN_U]), 32'd1);

    // C bouncing with the same period as the sample tick, then released.
    apply_reset(5'b00000);
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) raw[BTN_C] = ~raw[BTN_C];
      step();
    end
    raw[BTN_C] = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check("center_no_pulse", 32'(pcnt[BTN_C]), 32'd0);
    check("center_never_level", 32'(seen_level[BTN_C]), 32'd0);

    // D held for 30 debounced ticks: edge pulse plus six repeats.
    apply_reset(5'b01000);
    for (int i = 0; i < 200; i++) begin
      if (n == 119) raw[BTN_D] = 1'b0;
      step();
    end
    check("down_pulse_count", 32'(dq.size()), 32'd7);
    for (int k = 0; k < 7; k++)
      check("down_pulse_cycle", 32'((k < dq.size()) ? dq[k] : -1), 32'(13 + TD * jl[k]));

    // U held, D joins two ticks later: one press each, no repeats.
    apply_reset(5'b10000);
    for (int i = 0; i < 120; i++) begin
      if (n == 8) raw[BTN_D] = 1'b1;
      step();
    end
    check("conflict_up_count", 32'(pcnt[BTN_U]), 32'd1);
    check("conflict_down_count", 32'(pcnt[BTN_D]), 32'd1);
    raw[BTN_D] = 1'b0;
    for (int i = 0; i < 120; i++) step();
    check("conflict_up_no_restart", 32'(pcnt[BTN_U]), 32'd1);
    check("conflict_down_release", 32'(pcnt[BTN_D]), 32'd1);

    // R held across reset release for 50 ticks.
    apply_reset(5'b00100);
    for (int i = 0; i < 200; i++) step();
    check("right_single_pulse", 32'(pcnt[BTN_R]), 32'd1);

    // Random presses, bounces and holds on all buttons with a mid-run reset.
    apply_reset(5'($urandom_range(0, 31)));
    for (int b = 0; b < 5; b++) rem[b] = $urandom_range(1, 60);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset(raw);
      for (int b = 0; b < 5; b++) begin
        if (rem[b] == 0) begin
          raw[b] = ~raw[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 200);
        end else begin
          rem[b]--;
        end
      end
      step();
    end
    check("first_tick_after_midrun_reset", 32'(first_tick), 32'd4);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
